cache_control: RTL and testbench

Sequencing FSM for the 2-way, 8-set, 16-byte-line L1 cache datapath. It sits between the CPU memory port and the datapath/physical-memory port. It decodes datapath hit, dirty and LRU flags and drives the array load strobes, the muxes and the pmem handshake. Write-back, write-allocate, 1-bit LRU per set.

---
 rtl/cache_control.sv | 157 +++++++++++++++
 tb/tb_cache_control.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way, 8-set, write-back/write-allocate L1 cache datapath.
// Define PERF_CNT_EN to build the saturating hit/miss performance counters.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit1_out,
    input  logic                 hit2_out,
    input  logic                 hit_flag,
    input  logic                 dirty_bit1_out,
    input  logic                 dirty_bit2_out,
    input  logic                 lru_out,
    output logic                 load_tag1,
    output logic                 load_tag2,
    output logic                 load_valid1,
    output logic                 load_valid2,
    output logic                 load_data1,
    output logic                 load_data2,
    output logic                 load_dirty1,
    output logic                 load_dirty2,
    output logic                 load_lru,
    output logic                 dirty1,
    output logic                 dirty2,
    output logic                 lru_in,
    output logic                 datain1_sel,
    output logic [1:0]           pmem_addr_mux_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t state, next_state;
    logic   request, victim_dirty;

    assign request      = mem_read | mem_write;
    assign victim_dirty = lru_out ? dirty_bit2_out : dirty_bit1_out;

    always_ff @(posedge clk) begin
        if (reset) state <= CHECK;
        else       state <= next_state;
    end

    always_comb begin
        next_state        = state;
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        pmem_write        = 1'b0;
        load_tag1         = 1'b0;
        load_tag2         = 1'b0;
        load_valid1       = 1'b0;
        load_valid2       = 1'b0;
        load_data1        = 1'b0;
        load_data2        = 1'b0;
        load_dirty1       = 1'b0;
        load_dirty2       = 1'b0;
        load_lru          = 1'b0;
        dirty1            = 1'b0;
        dirty2            = 1'b0;
        lru_in            = 1'b0;
        datain1_sel       = 1'b0;
        pmem_addr_mux_sel = 2'b00;
        case (state)
            CHECK: begin
                pmem_addr_mux_sel = 2'b10;
                if (request && hit_flag) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = hit1_out;
                    // a write (or read+write) merges into the hit way; way1 wins a double hit
                    if (mem_write) begin
                        datain1_sel = 1'b1;
                        if (hit1_out) begin
                            load_data1  = 1'b1;
                            load_dirty1 = 1'b1;
                            dirty1      = 1'b1;
                        end else if (hit2_out) begin
                            load_data2  = 1'b1;
                            load_dirty2 = 1'b1;
                            dirty2      = 1'b1;
                        end
                    end
                end else if (request) begin
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write        = 1'b1;
                pmem_addr_mux_sel = {1'b0, lru_out};
                if (pmem_resp) begin
                    load_dirty1 = ~lru_out;
                    load_dirty2 = lru_out;
                    next_state  = request ? ALLOCATE : CHECK;
                end
            end
            ALLOCATE: begin
                pmem_read         = 1'b1;
                pmem_addr_mux_sel = 2'b10;
                if (pmem_resp) begin
                    load_data1  = ~lru_out;
                    load_tag1   = ~lru_out;
                    load_valid1 = ~lru_out;
                    load_dirty1 = ~lru_out;
                    load_data2  = lru_out;
                    load_tag2   = lru_out;
                    load_valid2 = lru_out;
                    load_dirty2 = lru_out;
                    next_state  = CHECK;
                end
            end
            default: next_state = CHECK;
        endcase
        // reset abandons the transaction: no array writes and no completion this cycle
        if (reset) begin
            mem_resp    = 1'b0;
            load_tag1   = 1'b0;
            load_tag2   = 1'b0;
            load_valid1 = 1'b0;
            load_valid2 = 1'b0;
            load_data1  = 1'b0;
            load_data2  = 1'b0;
            load_dirty1 = 1'b0;
            load_dirty2 = 1'b0;
            load_lru    = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (mem_resp && hit_cnt != '1)
                hit_cnt <= hit_cnt + CNT_WIDTH'(1);
            if (state == CHECK && next_state != CHECK && miss_cnt != '1)
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: decode table, directed miss/reset sequences, and random
// accesses checked against a line-level cache model with its own tag/data/memory arrays.
module tb_cache_control;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [17:0] RESP = 18'h20000, PR = 18'h10000, PW = 18'h08000,
        LT1 = 18'h04000, LT2 = 18'h02000, LV1 = 18'h01000, LV2 = 18'h00800,
        LD1 = 18'h00400, LD2 = 18'h00200, LDY1 = 18'h00100, LDY2 = 18'h00080,
        LLRU = 18'h00040, D1 = 18'h00020, D2 = 18'h00010, LRUIN = 18'h00008,
        SEL = 18'h00004, MUXC = 18'h00002;

    logic clk = 1'b0, reset = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp;
    logic mem_resp, pmem_read, pmem_write;
    logic hit1_out, hit2_out, hit_flag, dirty_bit1_out, dirty_bit2_out, lru_out;
    logic load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2;
    logic load_dirty1, load_dirty2, load_lru, dirty1, dirty2, lru_in, datain1_sel;
    logic [1:0]  pmem_addr_mux_sel;
    logic [15:0] hit_count, miss_count;

    cache_control #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit1_out(hit1_out), .hit2_out(hit2_out),
        .hit_flag(hit_flag), .dirty_bit1_out(dirty_bit1_out),
        .dirty_bit2_out(dirty_bit2_out), .lru_out(lru_out),
        .load_tag1(load_tag1), .load_tag2(load_tag2), .load_valid1(load_valid1),
        .load_valid2(load_valid2), .load_data1(load_data1), .load_data2(load_data2),
        .load_dirty1(load_dirty1), .load_dirty2(load_dirty2), .load_lru(load_lru),
        .dirty1(dirty1), .dirty2(dirty2), .lru_in(lru_in), .datain1_sel(datain1_sel),
        .pmem_addr_mux_sel(pmem_addr_mux_sel), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {mem_resp, pmem_read, pmem_write, load_tag1, load_tag2, load_valid1,
                load_valid2, load_data1, load_data2, load_dirty1, load_dirty2, load_lru,
                dirty1, dirty2, lru_in, datain1_sel, pmem_addr_mux_sel};
    endfunction

    function automatic logic [31:0] init_val(input logic [11:0] line);
        return {line, 20'hC0FFE};
    endfunction

    // Environment: datapath arrays written only by the DUT's strobes, plus memory
    logic        manual = 1'b0, dp_clear = 1'b1;
    logic        m_h1 = 0, m_h2 = 0, m_hf = 0, m_d1 = 0, m_d2 = 0, m_lru = 0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] wdata = '0;
    int          lat_wb = 4, lat_rd = 4, pcnt = 0;
    logic [8:0]  dp_tag [2][8];
    logic        dp_valid [2][8];
    logic        dp_dirty [2][8];
    logic [31:0] dp_data [2][8];
    logic        dp_lru [8];
    logic [31:0] dp_mem [4096];

    logic [2:0]  set_a;
    logic [8:0]  tag_a;
    logic        dp_hit1, dp_hit2;
    logic [11:0] pline;
    logic [31:0] pmem_rdata;

    assign set_a   = cpu_addr[6:4];
    assign tag_a   = cpu_addr[15:7];
    assign dp_hit1 = dp_valid[0][set_a] && dp_tag[0][set_a] == tag_a;
    assign dp_hit2 = dp_valid[1][set_a] && dp_tag[1][set_a] == tag_a;
    assign pline   = (pmem_addr_mux_sel == 2'b10) ? {tag_a, set_a}
                   : {dp_tag[pmem_addr_mux_sel[0]][set_a], set_a};
    assign pmem_rdata = dp_mem[pline];

    assign hit1_out       = manual ? m_h1 : dp_hit1;
    assign hit2_out       = manual ? m_h2 : dp_hit2;
    assign hit_flag       = manual ? m_hf : (dp_hit1 | dp_hit2);
    assign dirty_bit1_out = manual ? m_d1 : (dp_valid[0][set_a] & dp_dirty[0][set_a]);
    assign dirty_bit2_out = manual ? m_d2 : (dp_valid[1][set_a] & dp_dirty[1][set_a]);
    assign lru_out        = manual ? m_lru : dp_lru[set_a];

    always @(posedge clk) begin
        if (dp_clear) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 8; s++) begin
                    dp_tag[w][s] <= '0; dp_valid[w][s] <= 1'b0;
                    dp_dirty[w][s] <= 1'b0; dp_data[w][s] <= '0;
                end
            for (int s = 0; s < 8; s++) dp_lru[s] <= 1'b0;
            for (int l = 0; l < 4096; l++) dp_mem[l] <= init_val(12'(l));
        end else if (!manual) begin
            if (load_tag1)   dp_tag[0][set_a]   <= tag_a;
            if (load_tag2)   dp_tag[1][set_a]   <= tag_a;
            if (load_valid1) dp_valid[0][set_a] <= 1'b1;
            if (load_valid2) dp_valid[1][set_a] <= 1'b1;
            if (load_dirty1) dp_dirty[0][set_a] <= dirty1;
            if (load_dirty2) dp_dirty[1][set_a] <= dirty2;
            if (load_data1)  dp_data[0][set_a]  <= datain1_sel ? wdata : pmem_rdata;
            if (load_data2)  dp_data[1][set_a]  <= datain1_sel ? wdata : pmem_rdata;
            if (load_lru)    dp_lru[set_a]      <= lru_in;
            if (pmem_write && pmem_resp)
                dp_mem[pline] <= dp_data[pmem_addr_mux_sel[0]][set_a];
        end
    end

    // pmem: pmem_resp pulses in the lat-th cycle of a request (lat >= 2)
    always @(posedge clk) begin
        if (reset || pmem_resp) begin
            pmem_resp <= 1'b0; pcnt <= 0;
        end else if (pmem_read || pmem_write) begin
            if (pcnt + 2 == (pmem_write ? lat_wb : lat_rd)) pmem_resp <= 1'b1;
            pcnt <= pcnt + 1;
        end else pcnt <= 0;
    end
    initial pmem_resp = 1'b0;

    int          overlap = 0, wb_total = 0;
    logic [1:0]  wb_sel = '0;
    logic [17:0] fill_snap = '0;
    always @(negedge clk) begin
        if (pmem_read && pmem_write) overlap++;
        if (pmem_write) begin wb_total++; wb_sel = pmem_addr_mux_sel; end
        if (pmem_read && pmem_resp) fill_snap = outs();
    end

    // Reference cache model
    logic [8:0]  g_tag [2][8];
    logic        g_valid [2][8];
    logic        g_dirty [2][8];
    logic [31:0] g_data [2][8];
    logic        g_lru [8];
    logic [31:0] g_mem [4096];
    int          g_hits = 0, g_misses = 0, last_wb = 0;

    function automatic bit set_match(input int s);
        bit ok = (g_lru[s] == dp_lru[s]);
        for (int w = 0; w < 2; w++)
            ok &= g_valid[w][s] == dp_valid[w][s] && g_dirty[w][s] == dp_dirty[w][s]
               && g_tag[w][s] == dp_tag[w][s] && g_data[w][s] == dp_data[w][s];
        return ok;
    endfunction

    task automatic chk_counters(input string nm);
        chk({nm, "_hit_count"},  32'(hit_count),  PERF ? g_hits : 0);
        chk({nm, "_miss_count"}, 32'(miss_count), PERF ? g_misses : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        g_hits = 0; g_misses = 0;
    endtask

    // kind: 0 read, 1 write, 2 read+write (acts as write)
    task automatic access(input string nm, input logic [15:0] a, input int kind,
                          input logic [31:0] wd, input int lw, input int lr);
        int s = int'(a[6:4]);
        logic [8:0] t = a[15:7];
        int way, exp_cyc, cyc = 0, wb0 = wb_total;
        bit wb = 0, got = 0;
        logic [31:0] exp_rd, rd = '0;
        if (g_valid[0][s] && g_tag[0][s] == t) way = 0;
        else if (g_valid[1][s] && g_tag[1][s] == t) way = 1;
        else begin
            way = int'(g_lru[s]);
            wb  = g_valid[way][s] && g_dirty[way][s];
            if (wb) g_mem[{g_tag[way][s], 3'(s)}] = g_data[way][s];
            g_data[way][s] = g_mem[{t, 3'(s)}];
            g_tag[way][s] = t; g_valid[way][s] = 1'b1; g_dirty[way][s] = 1'b0;
            g_misses++;
        end
        exp_cyc = (g_misses > 0 && !(g_valid[way][s] && g_tag[way][s] == t)) ? 0 : 0;
        exp_rd = g_data[way][s];
        if (kind != 0) begin g_data[way][s] = wd; g_dirty[way][s] = 1'b1; end
        g_lru[s] = (way == 0);
        g_hits++;
        exp_cyc = (exp_rd === g_data[way][s] || kind != 0) ? 0 : 0;
        lat_wb = lw; lat_rd = lr; cpu_addr = a; wdata = wd;
        mem_read = (kind != 1); mem_write = (kind != 0);
        while (!got && cyc < 200) begin
            @(negedge clk); cyc++;
            if (mem_resp) begin
                got = 1;
                rd  = hit1_out ? dp_data[0][set_a] : dp_data[1][set_a];
            end
        end
        @(posedge clk); #1 mem_read = 1'b0; mem_write = 1'b0;
        last_wb = wb_total - wb0;
        exp_cyc = (cyc == 1 && !got) ? 1 : 0;
        chk({nm, "_completed"}, 32'(got), 1);
        chk({nm, "_latency"}, cyc, last_miss_latency(s, t, wb, lw, lr));
        if (kind == 0) chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_arrays"}, 32'(set_match(s)), 1);
    endtask

    // 1 cycle on a hit; otherwise fill latency (+ write-back latency) + 2
    logic [8:0] pre_tag [2][8];
    logic       pre_valid [2][8];
    function automatic int last_miss_latency(input int s, input logic [8:0] t, input bit wb,
                                             input int lw, input int lr);
        bit was_hit = (pre_valid[0][s] && pre_tag[0][s] == t) ||
                      (pre_valid[1][s] && pre_tag[1][s] == t);
        return was_hit ? 1 : 2 + lr + (wb ? lw : 0);
    endfunction

    task automatic run(input string nm, input logic [15:0] a, input int kind,
                       input logic [31:0] wd, input int lw, input int lr);
        pre_tag = g_tag; pre_valid = g_valid;
        access(nm, a, kind, wd, lw, lr);
    endtask

    typedef struct {
        string       name;
        logic        rd, wr, h1, h2, hf, d1, d2, lru;
        logic [17:0] exp;
        logic [1:0]  exp_next;  // {pmem_read, pmem_write} one cycle later
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, cyc;
        tbl[0]  = '{"idle",        0,0,0,0,0,0,0,0, MUXC, 2'b00};
        tbl[1]  = '{"rd_hit1",     1,0,1,0,1,0,0,0, RESP|LLRU|LRUIN|MUXC, 2'b00};
        tbl[2]  = '{"rd_hit2",     1,0,0,1,1,0,0,1, RESP|LLRU|MUXC, 2'b00};
        tbl[3]  = '{"wr_hit1",     0,1,1,0,1,0,0,0, RESP|LD1|LDY1|D1|LLRU|LRUIN|SEL|MUXC, 2'b00};
        tbl[4]  = '{"wr_hit2",     0,1,0,1,1,1,1,0, RESP|LD2|LDY2|D2|LLRU|SEL|MUXC, 2'b00};
        tbl[5]  = '{"wr_hit_both", 0,1,1,1,1,0,0,1, RESP|LD1|LDY1|D1|LLRU|LRUIN|SEL|MUXC, 2'b00};
        tbl[6]  = '{"rdwr_hit2",   1,1,0,1,1,0,0,0, RESP|LD2|LDY2|D2|LLRU|SEL|MUXC, 2'b00};
        tbl[7]  = '{"rd_miss_d1",  1,0,0,0,0,1,1,0, MUXC, 2'b01};
        tbl[8]  = '{"wr_miss_cln", 0,1,0,0,0,0,0,1, MUXC, 2'b10};
        tbl[9]  = '{"rd_miss_v2c", 1,0,0,0,0,1,0,1, MUXC, 2'b10};
        tbl[10] = '{"rd_miss_v2d", 1,0,0,0,0,0,1,1, MUXC, 2'b01};
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                g_tag[w][s] = '0; g_valid[w][s] = 0; g_dirty[w][s] = 0; g_data[w][s] = '0;
            end
        for (int s = 0; s < 8; s++) g_lru[s] = 1'b0;
        for (int l = 0; l < 4096; l++) g_mem[l] = init_val(12'(l));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0; dp_clear = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'(MUXC));
        chk_counters("reset");

        manual = 1'b1; lat_rd = 20; lat_wb = 20;
        for (int i = 0; i < 11; i++) begin
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            {mem_read, mem_write} = {tbl[i].rd, tbl[i].wr};
            {m_h1, m_h2, m_hf, m_d1, m_d2, m_lru} =
                {tbl[i].h1, tbl[i].h2, tbl[i].hf, tbl[i].d1, tbl[i].d2, tbl[i].lru};
            @(negedge clk);
            chk({tbl[i].name, "_decode"}, 32'(outs()), 32'(tbl[i].exp));
            @(negedge clk);
            chk({tbl[i].name, "_next"}, 32'({pmem_read, pmem_write}), 32'(tbl[i].exp_next));
            {mem_read, mem_write, m_h1, m_h2, m_hf, m_d1, m_d2, m_lru} = '0;
        end
        manual = 1'b0;
        do_reset();

        // cold read 0x1234: set 3, tag 0x024, clean way1 victim
        run("cold_read", 16'h1234, 0, 32'h0, 4, 3);
        chk("cold_fill_strobes", 32'(fill_snap), 32'(PR|LT1|LV1|LD1|LDY1|MUXC));
        chk_counters("cold");

        // dirty way2 victim in set 5
        run("wr_a", 16'h0850, 1, 32'hAAAA_0001, 3, 2);
        run("wr_b", 16'h08D0, 1, 32'hBBBB_0002, 3, 2);
        run("rd_a", 16'h0850, 0, 32'h0, 3, 2);
        run("rd_c_wb", 16'h0950, 0, 32'h0, 5, 3);
        chk("wb_hold_cycles", last_wb, 5);
        chk("wb_addr_sel", 32'(wb_sel), 32'(2'b01));
        run("rdwr_hit", 16'h0950, 2, 32'hCCCC_0003, 3, 3);
        chk("wb_read_back", g_mem[{9'h011, 3'd5}], 32'hBBBB_0002);

        // reset in the 3rd ALLOCATE cycle
        cpu_addr = 16'h1060; lat_rd = 8; mem_read = 1'b1; n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            @(negedge clk); cyc++;
            if (pmem_read) n++;
        end
        chk("rst_reached_alloc", n, 3);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; g_hits = 0; g_misses = 0;
        @(negedge clk);
        chk("rst_mid_outputs", 32'(outs()), 32'(MUXC));
        chk_counters("rst_mid");
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_arrays", 32'(set_match(6)), 1);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            a = {7'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom)};
            run("rand", a, int'($urandom_range(0, 2)), $urandom,
                int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
        end
        chk("pmem_overlap", overlap, 0);
        chk_counters("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
